// File: rtl/work_dispatcher_pkg.sv
// Shared types and defaults for the work dispatcher and its round-robin picker.
package work_dispatcher_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } disp_state_t;

    localparam int DISP_DATA_WIDTH = 256;
    localparam int DISP_NUM_CORES  = 4;

    function automatic int core_idx_w(input int num_cores);
        return (num_cores <= 2) ? 1 : $clog2(num_cores);
    endfunction

endpackage

// File: rtl/work_dispatcher_if.sv
// FIFO read side and hash-core array signals seen by the work dispatcher.
interface work_dispatcher_if
    import work_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH = DISP_DATA_WIDTH,
    parameter int NUM_CORES  = DISP_NUM_CORES
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_re_en;
    logic [DATA_WIDTH-1:0] core_work;
    logic [NUM_CORES-1:0]  core_load;
    logic [NUM_CORES-1:0]  core_done;
    logic [NUM_CORES-1:0]  busy_mask;
    logic [31:0]           dispatched_count;

    modport master (
        input  fifo_empty, fifo_data, core_done,
        output fifo_re_en, core_work, core_load, busy_mask, dispatched_count
    );

    modport slave (
        output fifo_empty, fifo_data, core_done,
        input  fifo_re_en, core_work, core_load, busy_mask, dispatched_count
    );
endinterface

// File: rtl/work_dispatcher_rr_pick.sv
// Combinational first-free picker scanning from a start index with wrap-around.
module rr_pick
    import work_dispatcher_pkg::*;
#(
    parameter int NUM_CORES  = DISP_NUM_CORES,
    parameter int CORE_IDX_W = core_idx_w(NUM_CORES)
) (
    input  logic [NUM_CORES-1:0]  i_free,
    input  logic [CORE_IDX_W-1:0] i_start,
    output logic [CORE_IDX_W-1:0] o_index,
    output logic                  o_any_free
);
    int                    w_sum;
    logic [CORE_IDX_W-1:0] w_idx;

    // Descending scan so the candidate closest to i_start is written last and wins.
    always_comb begin
        o_index    = '0;
        o_any_free = 1'b0;
        w_sum      = 0;
        w_idx      = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            w_sum = int'(i_start) + k;
            if (w_sum >= NUM_CORES) begin
                w_sum = w_sum - NUM_CORES;
            end
            w_idx = CORE_IDX_W'(w_sum);
            if (i_free[w_idx]) begin
                o_index    = w_idx;
                o_any_free = 1'b1;
            end
        end
    end
endmodule

// File: rtl/work_dispatcher.sv
// Pops work items from the show-ahead FIFO and loads them into idle hash cores round-robin.
//   state    | meaning
//   ST_IDLE  | waiting for enable, a FIFO word and a free core; pops on entry to ISSUE
//   ST_ISSUE | broadcasting the popped item and strobing the granted core's load
module work_dispatcher
    import work_dispatcher_pkg::*;
#(
    parameter int DATA_WIDTH = DISP_DATA_WIDTH,
    parameter int NUM_CORES  = DISP_NUM_CORES,
    parameter int CORE_IDX_W = core_idx_w(NUM_CORES)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_enable,
    work_dispatcher_if.master disp
);
    disp_state_t           r_state;
    disp_state_t           w_next_state;
    logic [DATA_WIDTH-1:0] r_work;
    logic [CORE_IDX_W-1:0] r_grant;
    logic [CORE_IDX_W-1:0] r_rr_ptr;
    logic [CORE_IDX_W-1:0] w_pick_idx;
    logic [NUM_CORES-1:0]  r_busy;
    logic [NUM_CORES-1:0]  w_free;
    logic [NUM_CORES-1:0]  w_load;
    logic [31:0]           r_count;
    logic                  w_any_free;
    logic                  w_re_en;

    assign w_free = ~r_busy;

    rr_pick #(
        .NUM_CORES  (NUM_CORES),
        .CORE_IDX_W (CORE_IDX_W)
    ) u_pick (
        .i_free     (w_free),
        .i_start    (r_rr_ptr),
        .o_index    (w_pick_idx),
        .o_any_free (w_any_free)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_re_en      = 1'b0;
        w_load       = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_enable && !disp.fifo_empty && w_any_free) begin
                    w_re_en      = 1'b1;
                    w_next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_load       = NUM_CORES'(1) << r_grant;
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Load is OR-ed in after the done-clear so a coincident done cannot free a core being loaded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_work   <= '0;
            r_grant  <= '0;
            r_busy   <= '0;
            r_rr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_re_en) begin
                r_work  <= disp.fifo_data;
                r_grant <= w_pick_idx;
            end
            r_busy <= (r_busy & ~disp.core_done) | w_load;
            if (r_state == ST_ISSUE) begin
                r_rr_ptr <= (r_grant == CORE_IDX_W'(NUM_CORES - 1)) ? '0 : r_grant + 1'b1;
                r_count  <= r_count + 32'd1;
            end
        end
    end

    assign disp.fifo_re_en       = w_re_en;
    assign disp.core_work        = r_work;
    assign disp.core_load        = w_load;
    assign disp.busy_mask        = r_busy;
    assign disp.dispatched_count = r_count;
endmodule

// File: tb/tb_work_dispatcher.sv
// Directed bench for work_dispatcher: per-cycle model comparison plus literal checkpoints.
module tb_work_dispatcher;
    localparam int DW = 256;
    localparam int NC = 4;

    logic clk;
    logic resetn;
    logic tb_enable;

    work_dispatcher_if #(.DATA_WIDTH(DW), .NUM_CORES(NC)) dif ();

    work_dispatcher #(.DATA_WIDTH(DW), .NUM_CORES(NC), .CORE_IDX_W(2)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .i_enable (tb_enable),
        .disp     (dif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    logic [DW-1:0] fq[$];
    logic [DW-1:0] dummy;
    bit            pop_req;
    bit            force_req;

    // model: busy set, round-robin start, count, and a popped item awaiting its load
    logic [NC-1:0] m_busy;
    int            m_rr;
    logic [31:0]   m_count;
    bit            m_pend;
    int            m_core;
    logic [DW-1:0] m_work;
    int            g;
    logic [NC-1:0] exp_load;
    bit            exp_re;

    logic [DW-1:0] it_a, it_b, it_c, it_d, it_e, it_f, it_g, it_h, it_i, it_j;

    function automatic logic [DW-1:0] mk(input logic [31:0] n);
        return {8{n}};
    endfunction

    function automatic int pick(input logic [NC-1:0] busy, input int rr);
        for (int k = 0; k < NC; k++) begin
            if (!busy[(rr + k) % NC]) return (rr + k) % NC;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic refresh_fifo();
        dif.fifo_empty = (fq.size() == 0);
        dif.fifo_data  = (fq.size() == 0) ? '0 : fq[0];
    endtask

    task automatic push(input logic [DW-1:0] d);
        fq.push_back(d);
        refresh_fifo();
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        if (pop_req && fq.size() != 0) begin
            dummy = fq.pop_front();
        end
        refresh_fifo();
    endtask

    task automatic compare_cycle();
        if (!resetn) begin
            chk("rst_re_en", DW'(dif.fifo_re_en), '0);
            chk("rst_load", DW'(dif.core_load), '0);
            chk("rst_work", dif.core_work, '0);
            chk("rst_busy", DW'(dif.busy_mask), '0);
            chk("rst_count", DW'(dif.dispatched_count), '0);
            m_busy  = '0;
            m_rr    = 0;
            m_count = '0;
            m_pend  = 0;
            m_core  = 0;
            m_work  = '0;
            pop_req = 0;
        end else begin
            if (force_req) m_count = 32'hFFFF_FFFF;
            exp_load = '0;
            if (m_pend) exp_load[m_core] = 1'b1;
            g      = pick(m_busy, m_rr);
            exp_re = !m_pend && tb_enable && !dif.fifo_empty && (g >= 0);
            chk("re_en", DW'(dif.fifo_re_en), DW'(exp_re));
            chk("no_pop_empty", DW'(dif.fifo_re_en && dif.fifo_empty), '0);
            chk("core_load", DW'(dif.core_load), DW'(exp_load));
            chk("core_work", dif.core_work, m_work);
            chk("busy_mask", DW'(dif.busy_mask), DW'(m_busy));
            chk("count", DW'(dif.dispatched_count), DW'(m_count));
            pop_req = dif.fifo_re_en && !dif.fifo_empty;
            m_busy  = (m_busy & ~dif.core_done) | exp_load;
            if (m_pend) begin
                m_rr    = (m_core + 1) % NC;
                m_count = m_count + 32'd1;
                m_pend  = 0;
            end else if (exp_re) begin
                m_pend = 1;
                m_core = g;
                m_work = dif.fifo_data;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        pop_req   = 0;
        force_req = 0;
        m_busy = '0; m_rr = 0; m_count = '0; m_pend = 0; m_core = 0; m_work = '0;
        resetn        = 1'b0;
        tb_enable     = 1'b0;
        dif.core_done = '0;
        refresh_fifo();
        it_a = mk(32'hA000_000A); it_b = mk(32'hB000_000B); it_c = mk(32'hC000_000C);
        it_d = mk(32'hD000_000D); it_e = mk(32'hE000_000E); it_f = mk(32'hF000_000F);
        it_g = mk(32'h1234_5678); it_h = mk(32'h8765_4321); it_i = mk(32'h5A5A_A5A5);
        it_j = mk(32'h0BAD_F00D);

        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
        join_none

        repeat (3) cyc();
        #1;
        chk("lit_rst_busy", DW'(dif.busy_mask), '0);
        chk("lit_rst_count", DW'(dif.dispatched_count), '0);
        chk("lit_rst_work", dif.core_work, '0);
        resetn = 1'b1;
        cyc();

        // three items into four idle cores
        push(it_a); push(it_b); push(it_c);
        tb_enable = 1'b1;
        #1 chk("lit_t1_pop_a", DW'(dif.fifo_re_en), 1);
        cyc(); #1;
        chk("lit_t1_load_a", DW'(dif.core_load), DW'(4'b0001));
        chk("lit_t1_work_a", dif.core_work, it_a);
        chk("lit_t1_no_b2b", DW'(dif.fifo_re_en), 0);
        cyc(); #1 chk("lit_t1_pop_b", DW'(dif.fifo_re_en), 1);
        cyc(); #1;
        chk("lit_t1_load_b", DW'(dif.core_load), DW'(4'b0010));
        chk("lit_t1_work_b", dif.core_work, it_b);
        cyc();
        cyc(); #1;
        chk("lit_t1_load_c", DW'(dif.core_load), DW'(4'b0100));
        chk("lit_t1_work_c", dif.core_work, it_c);
        cyc(); #1;
        chk("lit_t1_count", DW'(dif.dispatched_count), 3);
        chk("lit_t1_busy", DW'(dif.busy_mask), DW'(4'b0111));
        chk("lit_t1_empty_no_pop", DW'(dif.fifo_re_en), 0);

        // fill the last core, then free core 2 with a done pulse
        push(it_d); push(it_e);
        #1 chk("lit_t2_pop_d", DW'(dif.fifo_re_en), 1);
        cyc(); #1 chk("lit_t2_load_d", DW'(dif.core_load), DW'(4'b1000));
        cyc(); #1;
        chk("lit_t2_all_busy", DW'(dif.busy_mask), DW'(4'b1111));
        chk("lit_t2_no_pop_busy", DW'(dif.fifo_re_en), 0);
        dif.core_done = 4'b0100;
        #1 chk("lit_t2_done_not_comb", DW'(dif.fifo_re_en), 0);
        cyc(); dif.core_done = '0;
        #1 chk("lit_t2_pop_e", DW'(dif.fifo_re_en), 1);
        cyc(); #1;
        chk("lit_t2_load_e", DW'(dif.core_load), DW'(4'b0100));
        chk("lit_t2_work_e", dif.core_work, it_e);
        cyc();

        // busy 1011 with rr_ptr 3: scan wraps past cores 3,0,1 to core 2
        dif.core_done = 4'b0100;
        push(it_f);
        cyc(); dif.core_done = '0;
        #1;
        chk("lit_t3_busy", DW'(dif.busy_mask), DW'(4'b1011));
        chk("lit_t3_rr", DW'(dut.r_rr_ptr), 3);
        cyc(); #1;
        chk("lit_t3_load_f", DW'(dif.core_load), DW'(4'b0100));
        chk("lit_t3_work_f", dif.core_work, it_f);
        cyc(); #1 chk("lit_t3_rr_after", DW'(dut.r_rr_ptr), 3);

        // done on core 1 coincident with its load
        dif.core_done = 4'b0010;
        cyc(); dif.core_done = '0;
        push(it_g);
        #1 chk("lit_t4_pop_g", DW'(dif.fifo_re_en), 1);
        cyc(); dif.core_done = 4'b0010;
        #1 chk("lit_t4_load_g", DW'(dif.core_load), DW'(4'b0010));
        cyc(); dif.core_done = 4'b1000;
        #1 chk("lit_t4_load_wins", DW'(dif.busy_mask), DW'(4'b1111));
        cyc();
        #1 chk("lit_t4_busy_0111", DW'(dif.busy_mask), DW'(4'b0111));
        cyc(); dif.core_done = '0;
        #1 chk("lit_t4_idle_done_noop", DW'(dif.busy_mask), DW'(4'b0111));

        // enable falls during ISSUE
        push(it_h); push(it_i);
        #1 chk("lit_t5_pop_h", DW'(dif.fifo_re_en), 1);
        cyc(); tb_enable = 1'b0;
        #1 chk("lit_t5_load_h", DW'(dif.core_load), DW'(4'b1000));
        cyc(); dif.core_done = 4'b0001;
        cyc(); dif.core_done = '0;
        #1 chk("lit_t5_no_pop_dis", DW'(dif.fifo_re_en), 0);
        cyc();
        #1 chk("lit_t5_no_pop_dis2", DW'(dif.fifo_re_en), 0);
        tb_enable = 1'b1;
        #1 chk("lit_t5_pop_i", DW'(dif.fifo_re_en), 1);

        // reset during ISSUE discards the popped item
        cyc(); resetn = 1'b0;
        #1;
        chk("lit_t5_rst_load", DW'(dif.core_load), '0);
        chk("lit_t5_rst_busy", DW'(dif.busy_mask), '0);
        chk("lit_t5_rst_count", DW'(dif.dispatched_count), '0);
        chk("lit_t5_rst_work", dif.core_work, '0);
        cyc(); resetn = 1'b1;

        // counter wrap
        force dut.r_count = 32'hFFFF_FFFF;
        force_req = 1;
        cyc();
        release dut.r_count;
        force_req = 0;
        push(it_j);
        cyc(); #1 chk("lit_t6_load_j", DW'(dif.core_load), DW'(4'b0001));
        cyc(); #1;
        chk("lit_t6_count_wrap", DW'(dif.dispatched_count), 0);
        chk("lit_t6_busy", DW'(dif.busy_mask), DW'(4'b0001));
        repeat (3) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/work_dispatcher.md
# work_dispatcher

Pops 256-bit mining work items from the synchronous show-ahead work FIFO and hands each one to an idle hash core, choosing among idle cores round-robin. Sits between the work FIFO's read side and the array of NUM_CORES hash cores. It tracks per-core busy state from load and done events and counts dispatched items for status readout.

## Interface

- DATA_WIDTH, 256, work item width; equals FIFO width.
- NUM_CORES, 4, number of hash cores; 2..16.
- CORE_IDX_W, 2, width of a core index; equals ceil(log2(NUM_CORES)).

- clk  in  1  clock; all state updates on posedge.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  dispatch permitted when high.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  DATA_WIDTH  FIFO head word; valid whenever fifo_empty is low (show-ahead).
- fifo_re_en  out  1  FIFO pop strobe; one pop per asserted cycle.
- core_work  out  DATA_WIDTH  work item broadcast to all cores.
- core_load  out  NUM_CORES  one-hot load strobe; bit i loads core i.
- core_done  in  NUM_CORES  per-core completion pulse.
- busy_mask  out  NUM_CORES  bit i high while core i holds work.
- dispatched_count  out  32  total items issued.

## Operation

- FSM states: IDLE, ISSUE.
- IDLE: dispatch condition = enable & !fifo_empty & (busy_mask != all ones).
  - When true: fifo_re_en = 1 this cycle (combinational from state and inputs); pick g = first core with busy_mask[g] = 0 scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CORES; at the edge work_reg <= fifo_data, grant_reg <= g, state <= ISSUE.
  - When false: fifo_re_en = 0, stay IDLE.
- ISSUE: core_load = one-hot(grant_reg), fifo_re_en = 0; at the edge busy_mask[grant_reg] <= 1, rr_ptr <= (grant_reg + 1) mod NUM_CORES, dispatched_count += 1, state <= IDLE. ISSUE always completes, regardless of enable.
- core_work = work_reg at all times; stable from the ISSUE cycle until the next pop.
- core_done[i] clears busy_mask[i] at the edge. Done on a core that is already idle has no effect.
- core_done[i] and the load of core i in the same cycle: load wins, and busy stays 1.
- Multiple done bits in one cycle: all are cleared.
- The done-clear is visible to the dispatch condition one cycle after the pulse. There is no combinational done-to-grant path.
- rr_ptr modulo arithmetic is exact for non-power-of-two NUM_CORES; a grant_reg of NUM_CORES-1 wraps rr_ptr to 0.
- dispatched_count wraps from 2^32-1 to 0.
- fifo_re_en is never asserted while fifo_empty is high.

## Timing

- Reset values: state IDLE, fifo_re_en 0, core_load 0, core_work 0, work_reg 0, grant_reg 0, busy_mask 0, rr_ptr 0, dispatched_count 0.
- Latency: dispatch condition true in cycle N, then fifo_re_en high in N, then core_load high in N+1, then busy_mask updated from N+2.
- Throughput: at most one item per 2 cycles; back-to-back pops are never issued.
- Reset asserted during ISSUE: an item already popped is discarded, core_load is not issued, and all state returns to reset values.
- enable falling while in IDLE: no new pop from that cycle onward.
- enable falling while in ISSUE: the pending load still issues.

## Structure

- Shared package holds:
  - the state enum (IDLE, ISSUE),
  - default constants DISP_DATA_WIDTH = 256, DISP_NUM_CORES = 4,
  - a CORE_IDX_W helper function.
- Sub-module rr_pick: a combinational round-robin first-free picker.
  - Inputs: free mask, start pointer.
  - Outputs: index, any_free.
  - Reused by the future result-collection arbiter.

## Test plan

- Reset then FIFO loaded with 3 items A, B, C, all cores idle, enable = 1 -> core_load pulses 0001, 0010, 0100 on cycles 1, 3, 5 carrying A, B, C; dispatched_count = 3; fifo_re_en never high while fifo_empty is high.
- All 4 cores busy, FIFO non-empty -> no fifo_re_en. Pulse core_done[2] -> fifo_re_en one cycle later, then core_load = 0100.
- busy_mask = 1011, rr_ptr = 3, item available -> grant skips core 3, wraps, and picks core 2; rr_ptr becomes 3.
- core_done[1] coincident with the ISSUE load of core 1 -> busy_mask[1] remains 1. A later standalone done on idle core 3 -> no change.
- enable dropped in the ISSUE cycle -> load still issues, and no further pops while enable = 0. Resetn pulsed during ISSUE -> no core_load, all outputs return to 0.
- dispatched_count preloaded (via force) to 32'hFFFF_FFFF, one dispatch -> count reads 0.
